// File: rtl/cpc_exp_uart.sv
// cpc_exp_uart: Z80 expansion-port 8N1 UART with TX/RX FIFOs at I/O ports PORT_HI:PORT_LO[7:1].{0,1}.
// Define CPC_EXP_UART_IRQ_EN to build the registered interrupt request and its enable bits.
module cpc_exp_uart #(
    parameter logic [7:0]  PORT_HI         = 8'hF8,
    parameter logic [7:0]  PORT_LO         = 8'hE0,
    parameter logic [15:0] CLK_DIV         = 16'd139,
    parameter int          FIFO_DEPTH_LOG2 = 3
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [15:0] cpu_addr,
    input  logic [7:0]  cpu_dout,
    output logic [7:0]  cpu_din,
    input  logic        iorq,
    input  logic        rd,
    input  logic        wr,
    input  logic        m1,
    output logic        irq,
    output logic        txd,
    input  logic        rxd
);
    localparam int          AW     = FIFO_DEPTH_LOG2;
    localparam int          DEPTH  = 1 << AW;
    localparam logic [15:0] DIV_M1 = CLK_DIV - 16'd1;
    localparam logic [15:0] HALF   = CLK_DIV >> 1;

    typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;

    // ---------------- bus decode ----------------
    logic sel, wr_sel, wr_sel_q, wr_stb, data_wr, ctrl_wr;
    logic rd_data_sel, rd_data_q;

    assign sel         = iorq & ~m1 & (cpu_addr[15:8] == PORT_HI) & (cpu_addr[7:1] == PORT_LO[7:1]);
    assign wr_sel      = sel & wr;
    assign wr_stb      = wr_sel & ~wr_sel_q;
    assign data_wr     = wr_stb & ~cpu_addr[0];
    assign ctrl_wr     = wr_stb & cpu_addr[0];
    assign rd_data_sel = sel & rd & ~cpu_addr[0];

    // ---------------- TX FIFO ----------------
    logic [7:0]  tx_mem [DEPTH];
    logic [AW:0] tx_wptr_q, tx_rptr_q;
    logic        tx_empty, tx_full, tx_push, tx_pop;
    logic [7:0]  tx_head;

    assign tx_empty = (tx_wptr_q == tx_rptr_q);
    assign tx_full  = (tx_wptr_q[AW] != tx_rptr_q[AW]) && (tx_wptr_q[AW-1:0] == tx_rptr_q[AW-1:0]);
    assign tx_head  = tx_mem[tx_rptr_q[AW-1:0]];
    // A pop in the same clk frees the slot, so a push into a full FIFO still lands.
    assign tx_push  = data_wr & (~tx_full | tx_pop);

    always_ff @(posedge clk) begin
        if (tx_push) tx_mem[tx_wptr_q[AW-1:0]] <= cpu_dout;
    end

    // ---------------- TX FSM ----------------
    state_t      tx_state_q, tx_state_d;
    logic [15:0] tx_cnt_q, tx_cnt_d;
    logic [2:0]  tx_bit_q, tx_bit_d;
    logic [7:0]  tx_shift_q, tx_shift_d;
    logic        txd_q, txd_d;

    always_comb begin
        tx_state_d = tx_state_q;
        tx_cnt_d   = tx_cnt_q + 16'd1;
        tx_bit_d   = tx_bit_q;
        tx_shift_d = tx_shift_q;
        txd_d      = txd_q;
        tx_pop     = 1'b0;
        case (tx_state_q)
            S_IDLE: begin
                tx_cnt_d = '0;
                txd_d    = 1'b1;
                if (!tx_empty) begin
                    tx_pop     = 1'b1;
                    tx_shift_d = tx_head;
                    tx_state_d = S_START;
                    txd_d      = 1'b0;
                end
            end
            S_START: begin
                if (tx_cnt_q == DIV_M1) begin
                    tx_cnt_d   = '0;
                    tx_bit_d   = '0;
                    tx_state_d = S_DATA;
                    txd_d      = tx_shift_q[0];
                end
            end
            S_DATA: begin
                if (tx_cnt_q == DIV_M1) begin
                    tx_cnt_d = '0;
                    if (tx_bit_q == 3'd7) begin
                        tx_state_d = S_STOP;
                        txd_d      = 1'b1;
                    end else begin
                        tx_bit_d   = tx_bit_q + 3'd1;
                        tx_shift_d = tx_shift_q >> 1;
                        txd_d      = tx_shift_q[1];
                    end
                end
            end
            default: begin
                if (tx_cnt_q == DIV_M1) begin
                    tx_cnt_d = '0;
                    if (!tx_empty) begin
                        tx_pop     = 1'b1;
                        tx_shift_d = tx_head;
                        tx_state_d = S_START;
                        txd_d      = 1'b0;
                    end else begin
                        tx_state_d = S_IDLE;
                        txd_d      = 1'b1;
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            tx_state_q <= S_IDLE;
            tx_cnt_q   <= '0;
            tx_bit_q   <= '0;
            tx_shift_q <= '0;
            txd_q      <= 1'b1;
            tx_wptr_q  <= '0;
            tx_rptr_q  <= '0;
            wr_sel_q   <= 1'b0;
            rd_data_q  <= 1'b0;
        end else begin
            tx_state_q <= tx_state_d;
            tx_cnt_q   <= tx_cnt_d;
            tx_bit_q   <= tx_bit_d;
            tx_shift_q <= tx_shift_d;
            txd_q      <= txd_d;
            tx_wptr_q  <= tx_wptr_q + {{AW{1'b0}}, tx_push};
            tx_rptr_q  <= tx_rptr_q + {{AW{1'b0}}, tx_pop};
            wr_sel_q   <= wr_sel;
            rd_data_q  <= rd_data_sel;
        end
    end

    assign txd = txd_q;

    // ---------------- RX FIFO ----------------
    logic [7:0]  rx_mem [DEPTH];
    logic [AW:0] rx_wptr_q, rx_rptr_q;
    logic        rx_empty, rx_full, rx_push, rx_pop, rx_done;
    logic [7:0]  rx_head;

    assign rx_empty = (rx_wptr_q == rx_rptr_q);
    assign rx_full  = (rx_wptr_q[AW] != rx_rptr_q[AW]) && (rx_wptr_q[AW-1:0] == rx_rptr_q[AW-1:0]);
    assign rx_head  = rx_mem[rx_rptr_q[AW-1:0]];
    assign rx_push  = rx_done & ~rx_full;
    // Pop on the trailing edge of the data read so the byte is stable for the whole cycle.
    assign rx_pop   = rd_data_q & ~rd_data_sel & ~rx_empty;

    // ---------------- RX FSM ----------------
    state_t      rx_state_q, rx_state_d;
    logic [15:0] rx_cnt_q, rx_cnt_d;
    logic [2:0]  rx_bit_q, rx_bit_d;
    logic [7:0]  rx_shift_q, rx_shift_d;
    logic        rxd_meta_q, rxd_sync_q, rxd_prev_q;
    logic        ferr_set;

    always_comb begin
        rx_state_d = rx_state_q;
        rx_cnt_d   = rx_cnt_q + 16'd1;
        rx_bit_d   = rx_bit_q;
        rx_shift_d = rx_shift_q;
        rx_done    = 1'b0;
        ferr_set   = 1'b0;
        case (rx_state_q)
            S_IDLE: begin
                rx_cnt_d = '0;
                if (rxd_prev_q && !rxd_sync_q) rx_state_d = S_START;
            end
            S_START: begin
                if (rx_cnt_q == HALF) begin
                    rx_cnt_d   = '0;
                    rx_bit_d   = '0;
                    rx_state_d = rxd_sync_q ? S_IDLE : S_DATA;
                end
            end
            S_DATA: begin
                if (rx_cnt_q == DIV_M1) begin
                    rx_cnt_d   = '0;
                    rx_shift_d = {rxd_sync_q, rx_shift_q[7:1]};
                    rx_bit_d   = rx_bit_q + 3'd1;
                    if (rx_bit_q == 3'd7) rx_state_d = S_STOP;
                end
            end
            default: begin
                if (rx_cnt_q == DIV_M1) begin
                    rx_cnt_d   = '0;
                    rx_state_d = S_IDLE;
                    rx_done    = rxd_sync_q;
                    ferr_set   = ~rxd_sync_q;
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rx_push) rx_mem[rx_wptr_q[AW-1:0]] <= rx_shift_q;
    end

    // ---------------- flags and enables ----------------
    logic rx_overrun_q, rx_overrun_d, frame_err_q, frame_err_d;
    logic irq_rx_en, irq_tx_en;

    // Set takes priority over a same-clk clear from the control register.
    assign rx_overrun_d = (rx_done & rx_full) | (rx_overrun_q & ~(ctrl_wr & cpu_dout[3]));
    assign frame_err_d  = ferr_set | (frame_err_q & ~(ctrl_wr & cpu_dout[4]));

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            rx_state_q   <= S_IDLE;
            rx_cnt_q     <= '0;
            rx_bit_q     <= '0;
            rx_shift_q   <= '0;
            rxd_meta_q   <= 1'b1;
            rxd_sync_q   <= 1'b1;
            rxd_prev_q   <= 1'b1;
            rx_wptr_q    <= '0;
            rx_rptr_q    <= '0;
            rx_overrun_q <= 1'b0;
            frame_err_q  <= 1'b0;
        end else begin
            rx_state_q   <= rx_state_d;
            rx_cnt_q     <= rx_cnt_d;
            rx_bit_q     <= rx_bit_d;
            rx_shift_q   <= rx_shift_d;
            rxd_meta_q   <= rxd;
            rxd_sync_q   <= rxd_meta_q;
            rxd_prev_q   <= rxd_sync_q;
            rx_wptr_q    <= rx_wptr_q + {{AW{1'b0}}, rx_push};
            rx_rptr_q    <= rx_rptr_q + {{AW{1'b0}}, rx_pop};
            rx_overrun_q <= rx_overrun_d;
            frame_err_q  <= frame_err_d;
        end
    end

`ifdef CPC_EXP_UART_IRQ_EN
    logic irq_rx_en_q, irq_rx_en_d, irq_tx_en_q, irq_tx_en_d, irq_q, irq_d;

    always_comb begin
        irq_rx_en_d = ctrl_wr ? cpu_dout[5] : irq_rx_en_q;
        irq_tx_en_d = ctrl_wr ? cpu_dout[6] : irq_tx_en_q;
        irq_d       = (irq_rx_en_q & ~rx_empty) | (irq_tx_en_q & tx_empty);
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            irq_rx_en_q <= 1'b0;
            irq_tx_en_q <= 1'b0;
            irq_q       <= 1'b0;
        end else begin
            irq_rx_en_q <= irq_rx_en_d;
            irq_tx_en_q <= irq_tx_en_d;
            irq_q       <= irq_d;
        end
    end

    assign irq_rx_en = irq_rx_en_q;
    assign irq_tx_en = irq_tx_en_q;
    assign irq       = irq_q;
`else
    assign irq_rx_en = 1'b0;
    assign irq_tx_en = 1'b0;
    assign irq       = 1'b0;
`endif

    // ---------------- read mux ----------------
    logic [7:0] status;

    always_comb begin
        status  = {irq, irq_tx_en, irq_rx_en, frame_err_q, rx_overrun_q,
                   tx_empty & (tx_state_q == S_IDLE), tx_full, ~rx_empty};
        cpu_din = 8'hFF;
        if (sel && rd) cpu_din = cpu_addr[0] ? status : (rx_empty ? 8'hFF : rx_head);
    end
endmodule

// File: doc/cpc_exp_uart.md
Name: cpc_exp_uart

Overview:
- Expansion-port peripheral. It answers Z80 I/O cycles driven by the motherboard's expansion port: cpu_addr, cpu_dout, iorq, rd, wr, m1.
- Provides a byte-wide serial port: TX FIFO feeding an 8N1 transmitter, RX deserializer feeding an RX FIFO.
- Read data returns on cpu_din, which the motherboard ANDs onto the CPU bus, so the idle value is 8'hFF.
- Optional interrupt request drives the motherboard irq input.

Parameters:
- PORT_HI, 8'hF8: required value of cpu_addr[15:8].
- PORT_LO, 8'hE0: required value of cpu_addr[7:1], i.e. PORT_LO[7:1]; PORT_LO[0] is ignored.
- CLK_DIV, 16'd139: clk cycles per serial bit, 16 MHz / 115200. Legal range 16..65535.
- FIFO_DEPTH_LOG2, 3: each FIFO holds 2^N bytes.

Ports:
- clk  in  1  system clock, same clock as the motherboard
- reset_n  in  1  synchronous active-low reset
- cpu_addr  in  16  Z80 address
- cpu_dout  in  8  Z80 write data
- cpu_din  out  8  read data to CPU; 8'hFF when not driving
- iorq  in  1  active-high IORQ
- rd  in  1  active-high RD
- wr  in  1  active-high WR
- m1  in  1  active-high M1; excludes interrupt-acknowledge cycles
- irq  out  1  active-high interrupt request
- txd  out  1  serial out, idle 1
- rxd  in  1  serial in, asynchronous

Behaviour:
- Select: sel = iorq & ~m1 & (cpu_addr[15:8]==PORT_HI) & (cpu_addr[7:1]==PORT_LO[7:1]). Register index is cpu_addr[0].
- Reset values: cpu_din=8'hFF; txd=1; irq=0; both FIFOs empty; all flags and enables 0; TX and RX FSMs IDLE.
- A reset asserted mid-frame aborts the frame and returns txd to 1 on the next clk.

Access timing:
- Write: acts once per bus cycle, on the rising edge of (sel & wr) detected against a registered copy.
- Read data is combinational: cpu_din = (sel & rd) ? reg : 8'hFF.
- Data-register pop happens once, on the falling edge of (sel & rd), so data is stable through the whole cycle.

Register 0, data:
- Write pushes cpu_dout into the TX FIFO. A push while full is dropped silently.
- Read returns the RX FIFO head, or 8'hFF if empty. Popping an empty FIFO is a no-op.

Register 1, status (read):
- [0] rx_avail
- [1] tx_full
- [2] tx_idle (FIFO empty and TX FSM in IDLE)
- [3] rx_overrun
- [4] frame_err
- [5] irq_rx_en
- [6] irq_tx_en
- [7] irq

Register 1, control (write):
- [5] and [6] load the two enables.
- [3]=1 clears rx_overrun; [4]=1 clears frame_err. Writing 0 to these bits has no effect.
- If a clear and a set of the same flag occur in the same clk, the set wins.

TX FSM (IDLE, START, DATA, STOP):
- IDLE pops the FIFO when it is non-empty and loads the shifter. txd=0 starts on the next clk.
- Each state lasts CLK_DIV clks. DATA sends 8 bits LSB first. STOP drives txd=1.
- From STOP: back-to-back to START if the FIFO is non-empty, otherwise IDLE.
- A push and a pop in the same clk are both honoured, including when the FIFO is full.

RX:
- rxd passes through a 2-flop synchroniser.
- RX FSM (IDLE, START, DATA, STOP):
  - IDLE: a falling edge starts the frame.
  - START: samples at CLK_DIV/2; if the sample is 1, treat it as a glitch and return to IDLE.
  - DATA: 8 samples, CLK_DIV apart.
  - STOP sample = 0: set frame_err and discard the byte.
  - STOP sample = 1: push the byte. If the FIFO is full, set rx_overrun and discard the new byte; FIFO contents are unchanged.
- Returns to IDLE immediately after the stop sample, so it can resync on the next start bit.
- FIFO pointers are FIFO_DEPTH_LOG2+1 bits; full/empty come from MSB compare; pointers wrap naturally.

Optional Feature:
- Macro: CPC_EXP_UART_IRQ_EN.
- Defined: irq registered, = (irq_rx_en & rx_avail) | (irq_tx_en & tx FIFO empty). It updates 1 clk after the causing event and is held until the condition clears; the motherboard's level-sensitive INT_n & ~irq combine relies on this.
- Not defined: irq is tied to 0, status[7] reads 0, enable bits read back 0 and are not stored.

Test Plan:
- Reset: reset_n=0 for 2 clks -> cpu_din=FF, txd=1, irq=0; status read at F8E1 = 8'h04.
- TX: OUT F8E0,0x55 -> txd low for 139 clks, then bits 1,0,1,0,1,0,1,0 (139 clks each), then stop high; status[2] returns to 1 after the stop bit.
- TX FIFO: 9 back-to-back OUTs to F8E0 with depth 8 while the transmitter is busy -> tx_full=1 after the 8th write; the 9th byte is never transmitted; all transmitted frames are contiguous.
- RX: drive frame 0xA3 on rxd -> rx_avail=1; IN F8E0 returns A3 and holds it for the whole rd pulse; the next status read shows rx_avail=0.
- RX errors: 9 frames without reads -> rx_overrun=1 and the FIFO holds the first 8 bytes; a frame with stop bit 0 -> frame_err=1; OUT F8E1,0x18 clears both flags.
- IRQ/M1 (macro defined): OUT F8E1,0x20, then receive a byte -> irq=1 one clk after the push, and irq=0 after the pop. An M1+IORQ cycle at F8E0 -> cpu_din=FF and no pop.
